// File: rtl/display_page_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : display_page_sequencer
// Description : Latches a 64-bit text word and pages through its four 16-bit
//               slices, either on a dwell timer (auto) or by buttons (manual).
// Revision    : 1.0 - initial release
// ============================================================================
module display_page_sequencer #(
    parameter int DWELL = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1hz,
    input  logic [64:1] text_in,
    input  logic        text_valid,
    input  logic        mode,
    input  logic        btn_next,
    input  logic        btn_prev,
    output logic [1:0]  page,
    output logic [63:0] text_out,
    output logic        blank,
    output logic        text_ack,
    output logic        wrap
);

    localparam logic [3:0] c_dwell_last = 4'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        AUTO   = 2'd2,
        MANUAL = 2'd3
    } state_t;

    state_t      r_state, w_state_n;
    logic [3:0]  r_dwell, w_dwell_n;
    logic [1:0]  r_page, w_page_n;
    logic [63:0] r_text, w_text_n;
    logic        r_blank, w_blank_n;
    logic        r_ack, w_ack_n;
    logic        r_wrap, w_wrap_n;
    logic        r_next_q, r_prev_q;
    logic        w_next_edge, w_prev_edge;

    assign w_next_edge = btn_next & ~r_next_q;
    assign w_prev_edge = btn_prev & ~r_prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_dwell  <= 4'd0;
            r_page   <= 2'd0;
            r_text   <= 64'd0;
            r_blank  <= 1'b1;
            r_ack    <= 1'b0;
            r_wrap   <= 1'b0;
            r_next_q <= 1'b0;
            r_prev_q <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_dwell  <= w_dwell_n;
            r_page   <= w_page_n;
            r_text   <= w_text_n;
            r_blank  <= w_blank_n;
            r_ack    <= w_ack_n;
            r_wrap   <= w_wrap_n;
            // Edge history tracks the buttons in every state so a press held
            // across a load or mode switch never fires later.
            r_next_q <= btn_next;
            r_prev_q <= btn_prev;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_dwell_n = r_dwell;
        w_page_n  = r_page;
        w_text_n  = r_text;
        w_blank_n = r_blank;
        w_ack_n   = 1'b0;
        w_wrap_n  = 1'b0;

        if (text_valid) begin
            // New text outranks everything and restarts at page 0.
            w_state_n = LOAD;
            w_text_n  = text_in;
            w_page_n  = 2'd0;
            w_dwell_n = 4'd0;
            w_blank_n = 1'b0;
            w_ack_n   = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_page_n  = 2'd0;
                    w_blank_n = 1'b1;
                end
                LOAD: begin
                    w_state_n = mode ? MANUAL : AUTO;
                end
                AUTO: begin
                    if (mode) begin
                        w_state_n = MANUAL;
                        w_dwell_n = 4'd0;
                    end else if (tick_1hz) begin
                        if (r_dwell == c_dwell_last) begin
                            w_dwell_n = 4'd0;
                            w_page_n  = r_page + 2'd1;
                            w_wrap_n  = (r_page == 2'd3);
                        end else begin
                            w_dwell_n = r_dwell + 4'd1;
                        end
                    end
                end
                MANUAL: begin
                    if (!mode) begin
                        w_state_n = AUTO;
                        w_dwell_n = 4'd0;
                    end else if (w_next_edge && !w_prev_edge) begin
                        w_page_n = r_page + 2'd1;
                    end else if (w_prev_edge && !w_next_edge) begin
                        w_page_n = r_page - 2'd1;
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    assign page     = r_page;
    assign text_out = r_text;
    assign blank    = r_blank;
    assign text_ack = r_ack;
    assign wrap     = r_wrap;

endmodule
`default_nettype wire

// File: doc/display_page_sequencer.md
DISPLAY_PAGE_SEQUENCER -- requirements
Module: display_page_sequencer

Interface
REQ-001 Parameter: DWELL, default 3, number of tick_1hz strobes each page is shown in auto mode (legal range 1..15).
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 tick_1hz  input  1  one-clk-wide strobe from the clock divider; advances the dwell counter.
REQ-005 text_in  input  64 ([64:1])  decrypted text word to display.
REQ-006 text_valid  input  1  one-cycle strobe; text_in is valid in this cycle.
REQ-007 mode  input  1  level; 0 = auto scroll, 1 = manual paging.
REQ-008 btn_next  input  1  debounced level button; steps forward one page.
REQ-009 btn_prev  input  1  debounced level button; steps back one page.
REQ-010 page  output  2  page select for the display mux; 0 = bits [16:1], 1 = [32:17], 2 = [48:33], 3 = [64:49].
REQ-011 text_out  output  64  latched copy of the last accepted text_in.
REQ-012 blank  output  1  high while no text has been accepted; the display shows nothing.
REQ-013 text_ack  output  1  one-cycle pulse acknowledging an accepted text_valid.
REQ-014 wrap  output  1  one-cycle pulse when auto scroll moves from page 3 to page 0.

Function
REQ-015 The FSM SHALL have four states: IDLE, LOAD, AUTO and MANUAL; all outputs are registered.
REQ-016 IDLE: blank=1 and page=0; buttons, mode changes and tick_1hz are ignored; text_valid moves to LOAD.
REQ-017 In any state, text_valid SHALL capture text_in into text_out on that edge and move to LOAD.
REQ-018 LOAD (one cycle): text_ack=1, blank=0, page=0, dwell counter=0; next state is AUTO if mode=0, else MANUAL.
REQ-019 text_ack SHALL be high exactly in the cycle after the accepting edge, once per text_valid.
REQ-020 AUTO: each tick_1hz increments the dwell counter; when a tick arrives with the counter at DWELL-1, the counter clears and page increments modulo 4.
REQ-021 AUTO: when page goes from 3 to 0, wrap SHALL pulse for one cycle, coincident with the page=0 update.
REQ-022 AUTO: btn_next and btn_prev SHALL be ignored.
REQ-023 AUTO with mode=1: move to MANUAL; page keeps its value and the dwell counter clears.
REQ-024 MANUAL: btn_next and btn_prev SHALL be rising-edge detected against a registered copy of the previous level.
REQ-025 MANUAL: a btn_next edge sets page to page+1 mod 4; a btn_prev edge sets page to page-1 mod 4; both edges in the same cycle leave page unchanged.
REQ-026 MANUAL: tick_1hz is ignored and wrap stays 0.
REQ-027 MANUAL with mode=0: move to AUTO with page kept and the dwell counter cleared, so the first auto advance comes DWELL ticks later.
REQ-028 Priority, highest first: reset, text_valid, mode change, button or tick. A page step or tick in the same cycle as text_valid is discarded.
REQ-029 A button held across a text_valid or mode change SHALL NOT produce an edge later; the edge registers update in every state.
REQ-030 A new text_valid during AUTO or MANUAL SHALL restart at page 0 through LOAD.

Reset
REQ-031 With rst=0 at a rising edge, the block SHALL enter IDLE.
REQ-032 Reset values: page=0, text_out=0, blank=1, text_ack=0, wrap=0, dwell counter=0, button edge registers=0.
REQ-033 Reset asserted mid-scroll or mid-LOAD SHALL abandon the operation; the held text is lost; no text_ack or wrap pulse follows.

Verification
REQ-034 Reset, then text_valid with text_in=64'h0123_4567_89AB_CDEF and mode=0 -> text_ack one cycle later, blank=0, page=0, text_out=64'h0123_4567_89AB_CDEF.
REQ-035 DWELL=3, AUTO, 12 tick_1hz strobes -> page 0,1,2,3,0 advancing every 3rd tick; wrap pulses exactly once, at the 12th tick.
REQ-036 MANUAL, page=0: btn_prev edge -> page=3; btn_next held high 10 cycles -> page=0 (one step only); btn_next and btn_prev rising together -> page unchanged.
REQ-037 AUTO, page=2, counter=2: mode->1 -> MANUAL, page=2; mode->0 -> AUTO, page=2, and the next advance comes after 3 further ticks.
REQ-038 MANUAL, page=2: text_valid with a btn_next edge in the same cycle -> page=0 after LOAD, new text latched, single text_ack.
REQ-039 AUTO, page=1: rst=0 for one cycle -> page=0, blank=1, text_out=0; ticks and buttons ignored until the next text_valid.
